// File: rtl/btn_debounce_multi.sv
// Multi-channel push-button debouncer: 2-flop sync, shared sample tick, per-channel stability counter and hold FSM.
// Level and pulses follow 2 clk plus STABLE_SAMPLES ticks; no backpressure. Optional auto-repeat via BTN_AUTO_REPEAT_EN.
module btn_debounce_multi #(
  parameter int N_CH           = 4,
  parameter int CLK_DIV        = 100,
  parameter int STABLE_SAMPLES = 8,
  parameter int LONG_TICKS     = 500000,
  parameter int REPEAT_TICKS   = 100000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] i_btn,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic [N_CH-1:0] o_long,
  output logic [N_CH-1:0] o_repeat
);

  localparam int DW    = $clog2(CLK_DIV);
  localparam int SW    = $clog2(STABLE_SAMPLES + 1);
  localparam int HMAX  = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int HW    = (HMAX > 2) ? $clog2(HMAX) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_SAMPLES - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0] HOLD_MAX  = {HW{1'b1}};

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd1;
  localparam logic [1:0] ST_HELD    = 2'd2;

  logic [N_CH-1:0] sync_meta;
  logic [N_CH-1:0] sync_btn;
  logic [DW-1:0]   div_cnt;
  logic            tick;

  logic [SW-1:0]   stab_cnt  [N_CH];
  logic [HW-1:0]   hold_cnt  [N_CH];
  logic [1:0]      hold_st   [N_CH];

  logic [N_CH-1:0] rise_evt;
  logic [N_CH-1:0] fall_evt;
  logic [N_CH-1:0] long_evt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_meta <= '0;
      sync_btn  <= '0;
    end else begin
      sync_meta <= i_btn;
      sync_btn  <= sync_meta;
    end
  end

  // Shared sample strobe; a clock enable only.
  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Release wins over a long event landing on the same tick.
  always_comb begin
    rise_evt = '0;
    fall_evt = '0;
    long_evt = '0;
    for (int i = 0; i < N_CH; i++) begin
      rise_evt[i] = tick && sync_btn[i] && !o_level[i] && (stab_cnt[i] == STAB_LAST);
      fall_evt[i] = tick && !sync_btn[i] && o_level[i] && (stab_cnt[i] == STAB_LAST);
      long_evt[i] = tick && (hold_st[i] == ST_PRESSED) && (hold_cnt[i] == LONG_LAST) && !fall_evt[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_level   <= '0;
      o_press   <= '0;
      o_release <= '0;
      for (int i = 0; i < N_CH; i++) begin
        stab_cnt[i] <= '0;
      end
    end else begin
      o_press   <= rise_evt;
      o_release <= fall_evt;
      for (int i = 0; i < N_CH; i++) begin
        if (tick) begin
          if (sync_btn[i] != o_level[i]) begin
            if (stab_cnt[i] == STAB_LAST) begin
              o_level[i]  <= ~o_level[i];
              stab_cnt[i] <= '0;
            end else begin
              stab_cnt[i] <= stab_cnt[i] + 1'b1;
            end
          end else begin
            stab_cnt[i] <= '0;
          end
        end
      end
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [HW-1:0] REP_LAST = HW'(REPEAT_TICKS - 1);

  logic [N_CH-1:0] rep_evt;

  always_comb begin
    rep_evt = '0;
    for (int i = 0; i < N_CH; i++) begin
      rep_evt[i] = tick && (hold_st[i] == ST_HELD) && (hold_cnt[i] == REP_LAST) && !fall_evt[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_repeat <= '0;
    end else begin
      o_repeat <= rep_evt;
    end
  end
`else
  assign o_repeat = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_long <= '0;
      for (int i = 0; i < N_CH; i++) begin
        hold_st[i]  <= ST_IDLE;
        hold_cnt[i] <= '0;
      end
    end else begin
      o_long <= long_evt;
      for (int i = 0; i < N_CH; i++) begin
        if (fall_evt[i]) begin
          hold_st[i]  <= ST_IDLE;
          hold_cnt[i] <= '0;
        end else if (rise_evt[i]) begin
          hold_st[i]  <= ST_PRESSED;
          hold_cnt[i] <= '0;
        end else begin
          case (hold_st[i])
            ST_PRESSED: begin
              if (tick) begin
                if (hold_cnt[i] == LONG_LAST) begin
                  hold_st[i]  <= ST_HELD;
                  hold_cnt[i] <= '0;
                end else begin
                  hold_cnt[i] <= hold_cnt[i] + 1'b1;
                end
              end
            end
            ST_HELD: begin
`ifdef BTN_AUTO_REPEAT_EN
              if (tick) begin
                if (hold_cnt[i] == REP_LAST) begin
                  hold_cnt[i] <= '0;
                end else begin
                  hold_cnt[i] <= hold_cnt[i] + 1'b1;
                end
              end
`else
              // Without repeat the count only saturates, so it never wraps.
              if (tick && (hold_cnt[i] != HOLD_MAX)) begin
                hold_cnt[i] <= hold_cnt[i] + 1'b1;
              end
`endif
            end
            default: begin
              hold_st[i]  <= ST_IDLE;
              hold_cnt[i] <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Directed bench for btn_debounce_multi (N_CH=2, CLK_DIV=4, STABLE_SAMPLES=3, LONG_TICKS=10, REPEAT_TICKS=3).
module tb_btn_debounce_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] i_btn;
  logic [1:0] o_level, o_press, o_release, o_long, o_repeat;

  btn_debounce_multi #(
    .N_CH(2), .CLK_DIV(4), .STABLE_SAMPLES(3), .LONG_TICKS(10), .REPEAT_TICKS(3)
  ) dut (
    .clk(clk), .rst(rst), .i_btn(i_btn),
    .o_level(o_level), .o_press(o_press), .o_release(o_release),
    .o_long(o_long), .o_repeat(o_repeat)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int press_n [2] = '{0, 0};
  int rel_n   [2] = '{0, 0};
  int long_n  [2] = '{0, 0};
  int rep_n   [2] = '{0, 0};
  int both_press_n = 0;
  int bad_n = 0;
  logic [1:0] prev_level = 2'b00;

  int bp [2];
  int br [2];
  int bl [2];
  int brp [2];
  int bboth;
  int el;

  // Pulse monitor: counts pulses and flags any press/release not coincident with a level edge.
  always @(posedge clk) begin
    #1;
    for (int c = 0; c < 2; c++) begin
      if (o_press[c]) begin
        press_n[c] <= press_n[c] + 1;
        if (!(o_level[c] && !prev_level[c])) bad_n <= bad_n + 1;
      end
      if (o_release[c]) begin
        rel_n[c] <= rel_n[c] + 1;
        if (!(!o_level[c] && prev_level[c])) bad_n <= bad_n + 1;
      end
      if (o_long[c])   long_n[c] <= long_n[c] + 1;
      if (o_repeat[c]) rep_n[c]  <= rep_n[c] + 1;
    end
    if (o_press == 2'b11) both_press_n <= both_press_n + 1;
    prev_level <= o_level;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic snap();
    for (int c = 0; c < 2; c++) begin
      bp[c]  = press_n[c];
      br[c]  = rel_n[c];
      bl[c]  = long_n[c];
      brp[c] = rep_n[c];
    end
    bboth = both_press_n;
  endtask

  task automatic wait_lvl(input string tag, input logic [1:0] mask, input logic [1:0] val,
                          input int budget, output int elapsed);
    elapsed = 0;
    while (((o_level & mask) != val) && (elapsed < budget)) begin
      @(negedge clk);
      elapsed++;
    end
    chk(tag, int'(o_level & mask), int'(val));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b0;
    i_btn = 2'b11;
    repeat (5) @(negedge clk);
    chk("rst_level",   int'(o_level),   0);
    chk("rst_press",   int'(o_press),   0);
    chk("rst_release", int'(o_release), 0);
    chk("rst_long",    int'(o_long),    0);
    chk("rst_repeat",  int'(o_repeat),  0);

    // Inputs held high through reset release must debounce to a fresh press on both channels.
    snap();
    rst = 1'b1;
    wait_lvl("rst_rel_level", 2'b11, 2'b11, 20, el);
    chk("rst_rel_latency_le14", (el <= 14) ? 1 : 0, 1);
    chk("rst_rel_press0", press_n[0] - bp[0], 1);
    chk("rst_rel_press1", press_n[1] - bp[1], 1);
    i_btn = 2'b00;
    wait_lvl("rst_rel_drop", 2'b11, 2'b00, 20, el);
    chk("rst_rel_release0", rel_n[0] - br[0], 1);
    chk("rst_rel_release1", rel_n[1] - br[1], 1);

    // Clean press and release on ch0.
    snap();
    i_btn = 2'b01;
    wait_lvl("clean_rise", 2'b01, 2'b01, 20, el);
    chk("clean_latency_le14", (el <= 14) ? 1 : 0, 1);
    chk("clean_press0", press_n[0] - bp[0], 1);
    i_btn = 2'b00;
    wait_lvl("clean_fall", 2'b01, 2'b00, 20, el);
    chk("clean_release0", rel_n[0] - br[0], 1);
    chk("clean_press1",   press_n[1] - bp[1], 0);
    chk("clean_release1", rel_n[1] - br[1], 0);
    chk("clean_level1",   int'(o_level[1]), 0);

    // Bounce: 6-clk half periods cover at most two ticks, never three.
    snap();
    for (int k = 0; k < 10; k++) begin
      i_btn[0] = ~i_btn[0];
      repeat (6) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    chk("bounce_level0",   int'(o_level[0]), 0);
    chk("bounce_press0",   press_n[0] - bp[0], 0);
    chk("bounce_release0", rel_n[0] - br[0], 0);
    i_btn = 2'b01;
    wait_lvl("bounce_settle", 2'b01, 2'b01, 20, el);
    chk("bounce_single_press", press_n[0] - bp[0], 1);
    i_btn = 2'b00;
    wait_lvl("bounce_drop", 2'b01, 2'b00, 20, el);

    // Long press on ch1: o_long exactly 10 ticks (40 clk) after the press edge.
    snap();
    i_btn = 2'b10;
    wait_lvl("long_rise", 2'b10, 2'b10, 20, el);
    chk("long_press1", press_n[1] - bp[1], 1);
    el = 0;
    while ((long_n[1] == bl[1]) && (el < 60)) begin
      @(negedge clk);
      el++;
    end
    chk("long_latency", el, 40);
`ifdef BTN_AUTO_REPEAT_EN
    el = 0;
    while ((rep_n[1] == brp[1]) && (el < 30)) begin
      @(negedge clk);
      el++;
    end
    chk("repeat_first_gap", el, 12);
    el = 0;
    while ((rep_n[1] == brp[1] + 1) && (el < 30)) begin
      @(negedge clk);
      el++;
    end
    chk("repeat_second_gap", el, 12);
`else
    repeat (200) @(negedge clk);
    chk("no_repeat", rep_n[1] - brp[1], 0);
`endif
    chk("long_once", long_n[1] - bl[1], 1);
    i_btn = 2'b00;
    wait_lvl("long_fall", 2'b10, 2'b00, 20, el);
    chk("long_release1", rel_n[1] - br[1], 1);
    repeat (60) @(negedge clk);
    chk("long_none_after_release", long_n[1] - bl[1], 1);
    chk("long_ch0_quiet", long_n[0] - bl[0], 0);

    // Simultaneous press, then async reset mid-hold and fresh re-debounce.
    snap();
    i_btn = 2'b11;
    wait_lvl("simul_rise", 2'b11, 2'b11, 20, el);
    chk("simul_both_same_cycle", both_press_n - bboth, 1);
    chk("simul_press0", press_n[0] - bp[0], 1);
    chk("simul_press1", press_n[1] - bp[1], 1);
    repeat (8) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("async_rst_level", int'(o_level), 0);
    chk("async_rst_long",  int'(o_long),  0);
    repeat (3) @(negedge clk);
    snap();
    rst = 1'b1;
    wait_lvl("rerun_rise", 2'b11, 2'b11, 20, el);
    chk("rerun_latency_le14", (el <= 14) ? 1 : 0, 1);
    chk("rerun_press0", press_n[0] - bp[0], 1);
    chk("rerun_press1", press_n[1] - bp[1], 1);
    chk("rerun_release_none", (rel_n[0] - br[0]) + (rel_n[1] - br[1]), 0);

    repeat (2) @(negedge clk);
    chk("pulse_edge_alignment", bad_n, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/btn_debounce_multi.md
Name: btn_debounce_multi

Overview:
- Parametrised multi-channel successor to the single-button debouncer.
- Debounces N_CH asynchronous push-button inputs with a shared sample-tick divider and per-channel stability counters.
- Per channel it produces a clean level, one-clock press/release pulses, and a long-press pulse.
- Sits between board buttons and the watch/stopwatch control FSMs, replacing one debouncer instance per button.

Parameters:
- N_CH, 4, number of independent button channels (1..16)
- CLK_DIV, 100, clk cycles per sample tick (100 MHz -> 1 MHz); must be >=2
- STABLE_SAMPLES, 8, consecutive differing samples required to change debounced level; must be >=2
- LONG_TICKS, 500000, sample ticks of continuous press before o_long fires (0.5 s)
- REPEAT_TICKS, 100000, sample ticks between auto-repeat pulses (AUTO_REPEAT_EN only)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset (0 = reset)
- i_btn  input  N_CH  raw button inputs, asynchronous, active-high
- o_level  output  N_CH  debounced level per channel
- o_press  output  N_CH  one-clk pulse on debounced rising edge
- o_release  output  N_CH  one-clk pulse on debounced falling edge
- o_long  output  N_CH  one-clk pulse when press held LONG_TICKS
- o_repeat  output  N_CH  one-clk auto-repeat pulse (tied 0 without AUTO_REPEAT_EN)

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-low. All flops clear on rst=0. All outputs are 0 during and after reset, and all counters are 0.
- Synchroniser:
  - Each i_btn bit passes through a 2-flop synchroniser (sync[i]).
  - No logic uses i_btn directly.
- Tick generator:
  - Free-running counter 0..CLK_DIV-1, shared by all channels.
  - tick is a single-clk strobe asserted when the counter equals CLK_DIV-1; the counter then wraps to 0.
  - This is a clock enable only; no derived clocks.
- Stability counter (per channel, width clog2(STABLE_SAMPLES+1)):
  - On tick with sync[i] != o_level[i]: increment.
  - On tick with sync[i] == o_level[i]: clear to 0.
  - No change when there is no tick.
  - On a tick where sync[i] != o_level[i] and cnt == STABLE_SAMPLES-1: at that same edge o_level[i] toggles and cnt clears.
  - At that edge, o_press[i] (new level 1) or o_release[i] (new level 0) is registered high for exactly one clk.
- Latency: a clean step on i_btn appears on o_level after 2 clk (sync) plus STABLE_SAMPLES ticks, i.e. at most 2 + STABLE_SAMPLES*CLK_DIV clk.
- Glitch rejection: any sample that matches the current level restarts the count. Bounces shorter than STABLE_SAMPLES consecutive ticks never change o_level.
- Hold FSM (per channel), states IDLE, PRESSED, HELD:
  - IDLE -> PRESSED on the o_press event; the hold counter clears.
  - PRESSED:
    - Hold counter increments per tick.
    - When it reaches LONG_TICKS-1 on a tick: o_long pulses one clk, go to HELD, counter clears.
  - HELD: counter increments per tick (used by auto-repeat only).
  - Any state -> IDLE on the o_release event; the counter clears.
  - Release pre-empts a long/repeat event in the same cycle: no o_long/o_repeat on that edge.
- Channels are fully independent. Simultaneous events on different channels each produce their own pulses in the same cycle.
- Reset mid-operation: all state is lost immediately. After reset, an input still held high is re-debounced from scratch and yields a fresh o_press.
- Hold-counter width: clog2(max(LONG_TICKS, REPEAT_TICKS)). Counters saturate in HELD when AUTO_REPEAT_EN is absent, so there is no wrap.

Optional Feature:
- Macro: BTN_AUTO_REPEAT_EN.
- Defined:
  - In HELD, o_repeat[i] pulses one clk each time the hold counter reaches REPEAT_TICKS-1 on a tick; the counter then clears, so pulses are periodic every REPEAT_TICKS ticks while held.
  - The first repeat comes REPEAT_TICKS ticks after o_long.
- Not defined:
  - o_repeat is constant 0 and no repeat logic is synthesised.
  - The HELD counter saturates.

Test Plan (bench params: N_CH=2, CLK_DIV=4, STABLE_SAMPLES=3, LONG_TICKS=10, REPEAT_TICKS=3):
- Reset: hold rst=0 with i_btn=2'b11 -> all outputs 0. Release rst, keep inputs high -> o_level=2'b11 with one o_press pulse on both channels within 2+12 clk.
- Clean press ch0:
  - i_btn[0] 0->1 -> o_level[0] rises within 14 clk, with exactly one o_press[0] pulse in the same cycle.
  - Drop to 0 -> one o_release[0] pulse; ch1 outputs stay 0.
- Bounce rejection:
  - i_btn[0] toggles every 6 clk for 60 clk, from level 0 -> o_level[0] stays 0 and there are no pulses.
  - Then hold at 1 -> single o_press.
- Long press: hold ch1 high -> o_press[1]; o_long[1] pulses once after 10 further ticks (40 clk); release -> o_release[1], FSM back to IDLE.
- Auto-repeat (BTN_AUTO_REPEAT_EN defined): keep ch1 held -> o_repeat[1] pulses every 12 clk after o_long. Without the macro, o_repeat stays 0 for 200 clk.
- Simultaneous: both channels rise together -> both o_press bits high in the same cycle. Asserting rst=0 mid-hold clears o_level/FSM within the same cycle (async).
